// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential floating-point divider, q = n / d.
//
// One quotient bit per cycle (restoring division) after a one-cycle operand
// classification step. Subnormal operands and results are flushed to zero.
// At most one operation is in flight; operands and results use valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (aborts any operation)
//   in_valid   operand pair valid
//   in_ready   high only in IDLE while rst is low
//   n, d       dividend / divisor {sign, exp, frac}
//   out_valid  result valid, held until accepted
//   out_ready  consumer accepts the result
//   q          quotient
//   flags      {invalid, div_zero, overflow, underflow, inexact}
//
// Build option:
//   FP_DIV_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                            undefined -> truncate (round toward zero)
module fp_div_seq #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] n,
  input  logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic [4:0]   flags
);

  localparam int QW = MAN_W + 3;  // quotient bits: integer, fraction, guard, round
  localparam int RW = MAN_W + 2;  // partial remainder width
  localparam int EW = EXP_W + 2;  // signed working exponent width
  localparam int CW = $clog2(QW);

  localparam logic signed [EW-1:0] EXP_BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [CW-1:0]        LAST_ITER = CW'(QW - 1);
  localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam int F_INVALID = 4;
  localparam int F_DIVZ    = 3;
  localparam int F_OVF     = 2;
  localparam int F_UNF     = 1;
  localparam int F_INEXACT = 0;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_NORM, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           n_q, n_d, d_q, d_d;
  logic [RW-1:0]          rem_q, rem_d;
  logic [QW-1:0]          quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic [W-1:0]           res_q, res_d;
  logic [4:0]             res_flags_q, res_flags_d;
  logic [W-1:0]           q_q, q_d;
  logic [4:0]             flags_q, flags_d;
  logic                   out_valid_q, out_valid_d;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign flags     = flags_q;

  // Operand fields and classification (taken from the latched copies).
  logic                 sn, sd;
  logic [EXP_W-1:0]     en, ed;
  logic [MAN_W-1:0]     fn, fd;
  logic                 n_zero, n_inf, n_nan, d_zero, d_inf, d_nan;

  assign {sn, en, fn} = n_q;
  assign {sd, ed, fd} = d_q;
  assign n_zero = (en == '0);
  assign d_zero = (ed == '0);
  assign n_inf  = (&en) && (fn == '0);
  assign d_inf  = (&ed) && (fd == '0);
  assign n_nan  = (&en) && (fn != '0);
  assign d_nan  = (&ed) && (fd != '0);

  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic [4:0]   spec_flags;
  logic         sign_x;

  assign sign_x = sn ^ sd;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
      spec_res              = QNAN;
      spec_flags[F_INVALID] = 1'b1;
    end else if (d_zero && !n_inf) begin
      // Dividend is finite and non-zero here: the cases above took the rest.
      spec_res           = {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags[F_DIVZ] = 1'b1;
    end else if (n_zero || d_inf) begin
      spec_res = {sign_x, {(W-1){1'b0}}};
    end else if (n_inf) begin
      spec_res = {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step: subtract the divisor mantissa if it fits, then shift.
  logic [RW-1:0] div_man;
  logic          step_ge;
  logic [RW-1:0] rem_sub;

  assign div_man = {1'b0, 1'b1, fd};
  assign step_ge = (rem_q >= div_man);
  assign rem_sub = step_ge ? (rem_q - div_man) : rem_q;

  // Normalise, round and range-check the finished quotient.
  logic [MAN_W-1:0]     frac_n, frac_r;
  logic                 guard_n, round_n, sticky_n, inexact_n;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [W-1:0]         norm_res;
  logic [4:0]           norm_flags;
`ifdef FP_DIV_ROUND_NEAREST_EN
  logic                 round_up;
  logic [MAN_W+1:0]     mant_r;
`endif

  always_comb begin
    // A zero integer bit means the quotient is in [0.5, 1): shift it up one.
    if (quo_q[QW-1]) begin
      frac_n  = quo_q[QW-2:2];
      guard_n = quo_q[1];
      round_n = quo_q[0];
      exp_n   = exp_q;
    end else begin
      frac_n  = quo_q[QW-3:1];
      guard_n = quo_q[0];
      round_n = 1'b0;
      exp_n   = exp_q - EXP_ONE;
    end
    sticky_n  = |rem_q;
    inexact_n = guard_n | round_n | sticky_n;

`ifdef FP_DIV_ROUND_NEAREST_EN
    round_up = guard_n & (round_n | sticky_n | frac_n[0]);
    mant_r   = {1'b0, 1'b1, frac_n} + {{(MAN_W+1){1'b0}}, round_up};
    // Carry out of the mantissa: value is exactly 2.0, renormalise.
    if (mant_r[MAN_W+1]) begin
      frac_r = mant_r[MAN_W:1];
      exp_r  = exp_n + EXP_ONE;
    end else begin
      frac_r = mant_r[MAN_W-1:0];
      exp_r  = exp_n;
    end
`else
    frac_r = frac_n;
    exp_r  = exp_n;
`endif

    norm_flags = '0;
    norm_res   = {sign_q, exp_r[EXP_W-1:0], frac_r};
    if (exp_r >= EXP_MAX) begin
      norm_res              = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags[F_OVF]     = 1'b1;
      norm_flags[F_INEXACT] = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      norm_res              = {sign_q, {(W-1){1'b0}}};
      norm_flags[F_UNF]     = 1'b1;
      norm_flags[F_INEXACT] = 1'b1;
    end else begin
      norm_flags[F_INEXACT] = inexact_n;
    end
  end

  // Next-state logic for the controller and datapath registers.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    d_d         = d_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    res_d       = res_q;
    res_flags_d = res_flags_q;
    q_d         = q_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          n_d     = n;
          d_d     = d;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (spec_hit) begin
          res_d       = spec_res;
          res_flags_d = spec_flags;
          state_d     = S_DONE;
        end else begin
          rem_d   = {1'b0, 1'b1, fn};
          quo_d   = '0;
          cnt_d   = '0;
          sign_d  = sign_x;
          exp_d   = $signed({2'b00, en}) - $signed({2'b00, ed}) + EXP_BIAS;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = {rem_sub[RW-2:0], 1'b0};
        quo_d = {quo_q[QW-2:0], step_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_NORM;
      end
      S_NORM: begin
        res_d       = norm_res;
        res_flags_d = norm_flags;
        state_d     = S_DONE;
      end
      S_DONE: begin
        // Publish once, then hold q/flags steady until the consumer takes them.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          q_d         = res_q;
          flags_d     = res_flags_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset too, so an aborted operation
  // leaves nothing behind that a later read could mistake for a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      d_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      res_q       <= '0;
      res_flags_q <= '0;
      q_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      res_q       <= res_d;
      res_flags_q <= res_flags_d;
      q_q         <= q_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq at the default widths (8/23).
// Directed cases plus randomized operands, checked against an arithmetic
// reference model of the divider's rules.
module tb_fp_div_seq;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int LAT_NORMAL  = MAN_W + 6;
  localparam int LAT_SPECIAL = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] n;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [4:0]   flags;

  int n_cmp = 0;
  int n_bad = 0;

  fp_div_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {flags, q}. Exact quotient by integer division, then rounding
  // decided from the remainder.
  function automatic logic [W+4:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int     ea, eb, e;
    longint fa, fb, mn, md, num, qm, r;
    logic   s, inexact;
    logic   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [7:0]  e8;
    logic [22:0] f23;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    a_zero = (ea == 0);   b_zero = (eb == 0);
    a_inf  = (ea == 255) && (fa == 0);
    b_inf  = (eb == 255) && (fb == 0);
    a_nan  = (ea == 255) && (fa != 0);
    b_nan  = (eb == 255) && (fb != 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      return {5'b10000, 32'h7FC00000};
    if (b_zero && !a_inf) return {5'b01000, s, 8'hFF, 23'd0};
    if (a_zero || b_inf)  return {5'b00000, s, 31'd0};
    if (a_inf)            return {5'b00000, s, 8'hFF, 23'd0};
    mn = fa + (longint'(1) << 23);
    md = fb + (longint'(1) << 23);
    e  = ea - eb + 127;
    if (mn >= md) num = mn << 23;
    else begin
      num = mn << 24;
      e   = e - 1;
    end
    qm = num / md;
    r  = num % md;
    inexact = (r != 0);
`ifdef FP_DIV_ROUND_NEAREST_EN
    if ((2 * r > md) || ((2 * r == md) && (qm % 2 == 1))) qm = qm + 1;
    if (qm == (longint'(1) << 24)) begin
      qm = qm >> 1;
      e  = e + 1;
    end
`endif
    if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
    if (e <= 0)   return {5'b00011, s, 31'd0};
    e8  = 8'(e);
    f23 = 23'(qm);
    return {4'b0000, inexact, s, e8, f23};
  endfunction

  function automatic bit is_special(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [W-1:0] rnd_fp(input int base_exp);
    int sel;
    int e;
    sel = int'($urandom_range(0, 15));
    if (sel == 0)      e = 0;
    else if (sel == 1) e = 255;
    else begin
      e = base_exp + int'($urandom_range(0, 60)) - 30;
      if (e < 1)   e = 1;
      if (e > 254) e = 254;
    end
    return {1'($urandom), 8'(e), 23'($urandom)};
  endfunction

  // Present operands at a falling edge; accept happens at the next rising edge
  // (edge 0). Returns at the falling edge after edge 0 with scrambled inputs.
  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check({tag, " in_ready_idle"}, in_ready, 1);
    n        = a;
    d        = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n        = $urandom;
    d        = $urandom;
  endtask

  // Counts rising edges after the accept until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+4:0] r;
    int           lat;
    int           exp_lat;
    r       = ref_div(a, b);
    exp_lat = is_special(a, b) ? LAT_SPECIAL : LAT_NORMAL;
    start_op(tag, a, b);
    wait_result(lat);
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " q"}, q, r[W-1:0]);
    check({tag, " flags"}, flags, r[W+4:W]);
    @(negedge clk);
    check({tag, " valid_drop"}, out_valid, 0);
    check({tag, " in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    logic [W+4:0] r;
    int           lat;
    int           base;
    logic [W-1:0] a, b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = '0;
    d         = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset q", q, 0);
    check("reset flags", flags, 0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", in_ready, 1);

    // Directed cases.
    do_op("6/2", 32'h40C00000, 32'h40000000);
    do_op("1/3", 32'h3F800000, 32'h40400000);
`ifdef FP_DIV_ROUND_NEAREST_EN
    check("1/3 rne literal", q, 32'h3EAAAAAB);
`else
    check("1/3 trunc literal", q, 32'h3EAAAAAA);
`endif
    do_op("1/0", 32'h3F800000, 32'h00000000);
    check("1/0 literal", q, 32'h7F800000);
    do_op("0/0", 32'h00000000, 32'h00000000);
    check("0/0 literal", q, 32'h7FC00000);
    do_op("ovf", 32'h7F000000, 32'h00800000);
    do_op("unf", 32'h00800000, 32'h7F000000);
    do_op("inf/0", 32'hFF800000, 32'h00000000);
    do_op("0/inf", 32'h80000000, 32'h7F800000);
    do_op("nan/1", 32'h7FA00001, 32'h3F800000);
    do_op("-1/1", 32'hBF800000, 32'h3F800000);
    do_op("max/min", 32'h3FFFFFFF, 32'h3F800001);

    // Back-pressure: result and flags held while out_ready is low.
    out_ready = 1'b0;
    r = ref_div(32'h40C00000, 32'h40000000);
    start_op("hold", 32'h40C00000, 32'h40000000);
    wait_result(lat);
    check("hold latency", lat, LAT_NORMAL);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold out_valid", out_valid, 1);
      check("hold q", q, r[W-1:0]);
      check("hold flags", flags, r[W+4:W]);
      check("hold in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold release out_valid", out_valid, 0);
    check("hold release in_ready", in_ready, 1);

    // Reset in the middle of the iteration phase.
    start_op("abort", 32'h40C00000, 32'h40000000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort in_ready during rst", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort q", q, 0);
    check("abort flags", flags, 0);
    check("abort in_ready", in_ready, 1);
    do_op("after abort 6/2", 32'h40C00000, 32'h40000000);

    // Randomized operands around a random base exponent.
    for (int i = 0; i < 40; i++) begin
      base = int'($urandom_range(1, 254));
      a    = rnd_fp(base);
      b    = rnd_fp(base);
      do_op("random", a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
